halli_galli_engine: RTL and testbench

- N-player Halli Galli game core, generalising the fixed 2-player board game.
- Per player:
  - accepts debounced flip/bell button levels;
  - deals pseudo-random cards;
  - tracks top card, hand count and shared table pile;
  - resolves bell rings (collect or penalty);
  - rotates turn and detects game over.
- Sits between the button synchronisers and the LED/7-segment display drivers in the top level.

---
 rtl/hg_pkg.sv | 50 +++++
 rtl/hg_card_lfsr.sv | 53 +++++
 rtl/halli_galli_engine.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_halli_galli_engine.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hg_pkg
// Purpose  : Shared types and constants for the Halli Galli game core.
//            Holds the game state encoding, the largest card face value,
//            the LFSR feedback tap mask and width helper functions used to
//            size the player index, fruit and card-count buses.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hg_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    COLLECT = 2'd1,
    PENALTY = 2'd2,
    OVER    = 2'd3
  } hg_state_t;

  // Highest fruit count printed on a card; cards show 1..MAX_NUM fruits.
  localparam int MAX_NUM = 5;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

  // Ceiling log2, never narrower than one bit so 1-wide buses stay legal.
  function automatic int hg_clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 24; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int hg_fruit_w(input int num_fruits);
    return hg_clog2(num_fruits);
  endfunction

  function automatic int hg_pidx_w(input int num_players);
    return hg_clog2(num_players);
  endfunction

  // Counts must hold every card in play at once, hence players*deck + 1 values.
  function automatic int hg_cnt_w(input int num_players, input int deck_init);
    return hg_clog2(num_players * deck_init + 1);
  endfunction

endpackage : hg_pkg
`default_nettype wire

// File: rtl/hg_card_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : hg_card_lfsr
// Purpose  : Free-running 16-bit Fibonacci LFSR and the mapping of its state
//            to a card (fruit type and fruit count). A debug override can
//            replace the generated card with a forced one.
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            i_dbg_load       - select forced card instead of the LFSR card
//            i_dbg_fruit/num  - forced fruit type / fruit count
//            o_fruit/o_num    - card presented to the game core
// Revision : 1.0 - initial release
// ============================================================================
module hg_card_lfsr
  import hg_pkg::*;
#(
  parameter  int          NUM_FRUITS = 4,
  parameter  logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int          FRUIT_W    = hg_fruit_w(NUM_FRUITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_dbg_load,
  input  logic [FRUIT_W-1:0] i_dbg_fruit,
  input  logic [2:0]         i_dbg_num,
  output logic [FRUIT_W-1:0] o_fruit,
  output logic [2:0]         o_num
);

  logic [15:0]        r_lfsr;
  logic               w_fb;
  logic [FRUIT_W-1:0] w_rand_fruit;
  logic [2:0]         w_rand_num;

  assign w_fb = ^(r_lfsr & c_LFSR_TAPS);

  // Advances on every clock regardless of game state, so card values depend
  // on the exact cycle a player presses the flip button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign w_rand_fruit = FRUIT_W'(r_lfsr[7:0] % 8'(NUM_FRUITS));
  assign w_rand_num   = 3'(r_lfsr[15:8] % 8'(MAX_NUM)) + 3'd1;

  assign o_fruit = i_dbg_load ? i_dbg_fruit : w_rand_fruit;
  assign o_num   = i_dbg_load ? i_dbg_num   : w_rand_num;

endmodule : hg_card_lfsr
`default_nettype wire

// File: rtl/halli_galli_engine.sv
`default_nettype none
// ============================================================================
// Module   : halli_galli_engine
// Purpose  : N-player Halli Galli game core. Detects flip/bell button edges,
//            deals cards, keeps hand counts, the table pile and each player's
//            top card, resolves bell rings (collect the pile on a valid ring,
//            pay one card to every other active player on an invalid one),
//            rotates the turn and detects the end of the game.
// Ports    : clk, rst                - clock, asynchronous active-high reset
//            flip_btn, bell_btn      - debounced button levels, 1 bit/player
//            dbg_load/fruit/num      - forced card for the next flip
//            turn                    - player expected to flip
//            card_cnt, pile_cnt      - hand counts (P0 in LSBs), table pile
//            top_fruit, top_num      - top card per player (num 0 = none)
//            ring_ok, ring_bad       - one-cycle ring result pulses
//            busy                    - high while collecting / penalising
//            game_over, winner       - end-of-game level and winner index
// Revision : 1.0 - initial release
// ============================================================================
module halli_galli_engine
  import hg_pkg::*;
#(
  parameter  int          NUM_PLAYERS = 2,
  parameter  int          NUM_FRUITS  = 4,
  parameter  int          TARGET      = 5,
  parameter  int          DECK_INIT   = 28,
  parameter  logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int          FRUIT_W     = hg_fruit_w(NUM_FRUITS),
  localparam int          PIDX_W      = hg_pidx_w(NUM_PLAYERS),
  localparam int          CNT_W       = hg_cnt_w(NUM_PLAYERS, DECK_INIT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PLAYERS-1:0]         flip_btn,
  input  logic [NUM_PLAYERS-1:0]         bell_btn,
  input  logic                           dbg_load,
  input  logic [FRUIT_W-1:0]             dbg_fruit,
  input  logic [2:0]                     dbg_num,
  output logic [PIDX_W-1:0]              turn,
  output logic [NUM_PLAYERS*CNT_W-1:0]   card_cnt,
  output logic [CNT_W-1:0]               pile_cnt,
  output logic [NUM_PLAYERS*FRUIT_W-1:0] top_fruit,
  output logic [NUM_PLAYERS*3-1:0]       top_num,
  output logic                           ring_ok,
  output logic                           ring_bad,
  output logic                           busy,
  output logic                           game_over,
  output logic [PIDX_W-1:0]              winner
);

  // ---------------------------------------------------------------- state
  hg_state_t            r_state, w_state_n;
  logic [CNT_W-1:0]     r_cnt [NUM_PLAYERS];
  logic [CNT_W-1:0]     w_cnt_n [NUM_PLAYERS];
  logic [FRUIT_W-1:0]   r_tf [NUM_PLAYERS];
  logic [FRUIT_W-1:0]   w_tf_n [NUM_PLAYERS];
  logic [2:0]           r_tn [NUM_PLAYERS];
  logic [2:0]           w_tn_n [NUM_PLAYERS];
  logic [CNT_W-1:0]     r_pile, w_pile_n;
  logic [PIDX_W-1:0]    r_turn, w_turn_n;
  logic [PIDX_W-1:0]    r_ringer, w_ringer_n;
  logic [PIDX_W-1:0]    r_last, w_last_n;
  logic [PIDX_W-1:0]    r_winner, w_winner_n;
  logic [NUM_PLAYERS-1:0] r_pen_mask, w_pen_mask_n;
  logic                 r_ring_ok, w_ring_ok_n;
  logic                 r_ring_bad, w_ring_bad_n;
  logic [NUM_PLAYERS-1:0] r_flip_q, r_bell_q;

  // ---------------------------------------------------------------- wires
  logic [NUM_PLAYERS-1:0] w_active, w_active_n;
  logic [NUM_PLAYERS-1:0] w_flip_ev, w_bell_ev;
  logic [FRUIT_W-1:0]   w_card_fruit;
  logic [2:0]           w_card_num;
  logic [5:0]           w_sum;
  logic                 w_hit;
  logic                 w_check_over, w_flip_turn, w_pen_exit;
  logic [PIDX_W-1:0]    w_rcp;
  int                   w_nact;

  function automatic logic [PIDX_W-1:0] f_lowest(input logic [NUM_PLAYERS-1:0] m);
    logic [PIDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (m[i]) idx = PIDX_W'(i);
    end
    return idx;
  endfunction

  // First set bit strictly after t, wrapping around; t itself is the last
  // candidate. Returns t when the mask is empty.
  function automatic logic [PIDX_W-1:0] f_next_active(input logic [PIDX_W-1:0] t,
                                                      input logic [NUM_PLAYERS-1:0] m);
    logic [PIDX_W-1:0] idx;
    logic              found;
    idx   = t;
    found = 1'b0;
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      if (!found && (j > int'(t)) && m[j]) begin
        idx   = PIDX_W'(j);
        found = 1'b1;
      end
    end
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      if (!found && (j <= int'(t)) && m[j]) begin
        idx   = PIDX_W'(j);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  hg_card_lfsr #(
    .NUM_FRUITS (NUM_FRUITS),
    .LFSR_SEED  (LFSR_SEED)
  ) u_card (
    .clk         (clk),
    .rst         (rst),
    .i_dbg_load  (dbg_load),
    .i_dbg_fruit (dbg_fruit),
    .i_dbg_num   (dbg_num),
    .o_fruit     (w_card_fruit),
    .o_num       (w_card_num)
  );

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_active[p] = (r_cnt[p] != '0);
    end
  end

  // Inactive players can neither flip nor ring.
  assign w_flip_ev = flip_btn & ~r_flip_q & w_active;
  assign w_bell_ev = bell_btn & ~r_bell_q & w_active;

  // A ring is valid when any single fruit totals exactly TARGET across the
  // visible top cards. Empty slots read as fruit 0 with count 0.
  always_comb begin
    w_hit = 1'b0;
    w_sum = '0;
    for (int f = 0; f < NUM_FRUITS; f++) begin
      w_sum = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (r_tf[p] == FRUIT_W'(f)) w_sum = w_sum + 6'(r_tn[p]);
      end
      if (w_sum == 6'(TARGET)) w_hit = 1'b1;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_tf_n       = r_tf;
    w_tn_n       = r_tn;
    w_pile_n     = r_pile;
    w_turn_n     = r_turn;
    w_ringer_n   = r_ringer;
    w_last_n     = r_last;
    w_winner_n   = r_winner;
    w_pen_mask_n = r_pen_mask;
    w_ring_ok_n  = 1'b0;
    w_ring_bad_n = 1'b0;
    w_check_over = 1'b0;
    w_flip_turn  = 1'b0;
    w_pen_exit   = 1'b0;
    w_rcp        = '0;
    w_active_n   = '0;
    w_nact       = 0;

    case (r_state)
      PLAY: begin
        if (w_bell_ev != '0) begin
          // A bell event wins over any flip in the same cycle.
          w_ringer_n   = f_lowest(w_bell_ev);
          w_pen_mask_n = w_active & ~(NUM_PLAYERS'(1) << w_ringer_n);
          if (w_hit) begin
            w_ring_ok_n = 1'b1;
            w_state_n   = COLLECT;
          end else begin
            w_ring_bad_n = 1'b1;
            w_state_n    = PENALTY;
          end
        end else if (w_flip_ev[r_turn]) begin
          w_tf_n[r_turn]  = w_card_fruit;
          w_tn_n[r_turn]  = w_card_num;
          w_cnt_n[r_turn] = r_cnt[r_turn] - CNT_W'(1);
          w_pile_n        = r_pile + CNT_W'(1);
          w_last_n        = r_turn;
          w_flip_turn     = 1'b1;
          w_check_over    = 1'b1;
        end
      end

      COLLECT: begin
        w_cnt_n[r_ringer] = r_cnt[r_ringer] + r_pile;
        w_pile_n          = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          w_tf_n[p] = '0;
          w_tn_n[p] = '0;
        end
        w_turn_n     = r_ringer;
        w_state_n    = PLAY;
        w_check_over = 1'b1;
      end

      PENALTY: begin
        if (r_pen_mask == '0) begin
          w_state_n    = PLAY;
          w_pen_exit   = 1'b1;
          w_check_over = 1'b1;
        end else begin
          // One card per cycle to the lowest remaining recipient.
          w_rcp               = f_lowest(r_pen_mask);
          w_cnt_n[r_ringer]   = r_cnt[r_ringer] - CNT_W'(1);
          w_cnt_n[w_rcp]      = r_cnt[w_rcp] + CNT_W'(1);
          w_pen_mask_n[w_rcp] = 1'b0;
          if ((w_cnt_n[r_ringer] == '0) || (w_pen_mask_n == '0)) begin
            w_state_n    = PLAY;
            w_pen_exit   = 1'b1;
            w_check_over = 1'b1;
          end
        end
      end

      OVER: begin
      end

      default: begin
        w_state_n = PLAY;
      end
    endcase

    // Turn and game-over decisions look at the hand counts after this step.
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_active_n[p] = (w_cnt_n[p] != '0);
      if (w_active_n[p]) w_nact = w_nact + 1;
    end

    if (w_flip_turn) begin
      w_turn_n = f_next_active(r_turn, w_active_n);
    end
    if (w_pen_exit && !w_active_n[r_turn]) begin
      w_turn_n = f_next_active(r_turn, w_active_n);
    end

    if (w_check_over && (w_nact <= 1)) begin
      w_state_n  = OVER;
      w_winner_n = (w_nact == 1) ? f_lowest(w_active_n) : w_last_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PLAY;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        r_cnt[p] <= CNT_W'(DECK_INIT);
        r_tf[p]  <= '0;
        r_tn[p]  <= '0;
      end
      r_pile     <= '0;
      r_turn     <= '0;
      r_ringer   <= '0;
      r_last     <= '0;
      r_winner   <= '0;
      r_pen_mask <= '0;
      r_ring_ok  <= 1'b0;
      r_ring_bad <= 1'b0;
      r_flip_q   <= '0;
      r_bell_q   <= '0;
    end else begin
      r_cnt      <= w_cnt_n;
      r_tf       <= w_tf_n;
      r_tn       <= w_tn_n;
      r_pile     <= w_pile_n;
      r_turn     <= w_turn_n;
      r_ringer   <= w_ringer_n;
      r_last     <= w_last_n;
      r_winner   <= w_winner_n;
      r_pen_mask <= w_pen_mask_n;
      r_ring_ok  <= w_ring_ok_n;
      r_ring_bad <= w_ring_bad_n;
      // Edge registers track the buttons in every state.
      r_flip_q   <= flip_btn;
      r_bell_q   <= bell_btn;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_out
    assign card_cnt[p*CNT_W +: CNT_W]      = r_cnt[p];
    assign top_fruit[p*FRUIT_W +: FRUIT_W] = r_tf[p];
    assign top_num[p*3 +: 3]               = r_tn[p];
  end

  assign turn      = r_turn;
  assign pile_cnt  = r_pile;
  assign ring_ok   = r_ring_ok;
  assign ring_bad  = r_ring_bad;
  assign busy      = (r_state == COLLECT) || (r_state == PENALTY);
  assign game_over = (r_state == OVER);
  assign winner    = r_winner;

endmodule : halli_galli_engine
`default_nettype wire

// File: tb/tb_halli_galli_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_halli_galli_engine
// Purpose  : Self-checking bench for halli_galli_engine. Three instances:
//            A (2 players, deck 28), B (4 players, deck 28) and
//            C (2 players, deck 1). Ring results are scoreboarded: the
//            expected pulse kind is queued when a bell is pressed and popped
//            when the design pulses ring_ok/ring_bad.
// Revision : 1.0 - initial release
// ============================================================================
module tb_halli_galli_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Shared debug card inputs (fruit width is 2 for every instance).
  logic       dbg_load;
  logic [1:0] dbg_fruit;
  logic [2:0] dbg_num;

  // Instance A: N=2, DECK=28 -> CNT_W=6
  logic [1:0]  a_flip, a_bell;
  logic [0:0]  a_turn, a_win;
  logic [11:0] a_card;
  logic [5:0]  a_pile, a_tn;
  logic [3:0]  a_tf;
  logic        a_ok, a_bad, a_busy, a_go;

  // Instance B: N=4, DECK=28 -> CNT_W=7
  logic [3:0]  b_flip, b_bell;
  logic [1:0]  b_turn, b_win;
  logic [27:0] b_card;
  logic [6:0]  b_pile;
  logic [7:0]  b_tf;
  logic [11:0] b_tn;
  logic        b_ok, b_bad, b_busy, b_go;

  // Instance C: N=2, DECK=1 -> CNT_W=2
  logic [1:0]  c_flip, c_bell;
  logic [0:0]  c_turn, c_win;
  logic [3:0]  c_card;
  logic [1:0]  c_pile;
  logic [3:0]  c_tf;
  logic [5:0]  c_tn;
  logic        c_ok, c_bad, c_busy, c_go;

  halli_galli_engine #(.NUM_PLAYERS(2), .DECK_INIT(28)) u_a (
    .clk(clk), .rst(rst), .flip_btn(a_flip), .bell_btn(a_bell),
    .dbg_load(dbg_load), .dbg_fruit(dbg_fruit), .dbg_num(dbg_num),
    .turn(a_turn), .card_cnt(a_card), .pile_cnt(a_pile), .top_fruit(a_tf),
    .top_num(a_tn), .ring_ok(a_ok), .ring_bad(a_bad), .busy(a_busy),
    .game_over(a_go), .winner(a_win));

  halli_galli_engine #(.NUM_PLAYERS(4), .DECK_INIT(28)) u_b (
    .clk(clk), .rst(rst), .flip_btn(b_flip), .bell_btn(b_bell),
    .dbg_load(dbg_load), .dbg_fruit(dbg_fruit), .dbg_num(dbg_num),
    .turn(b_turn), .card_cnt(b_card), .pile_cnt(b_pile), .top_fruit(b_tf),
    .top_num(b_tn), .ring_ok(b_ok), .ring_bad(b_bad), .busy(b_busy),
    .game_over(b_go), .winner(b_win));

  halli_galli_engine #(.NUM_PLAYERS(2), .DECK_INIT(1)) u_c (
    .clk(clk), .rst(rst), .flip_btn(c_flip), .bell_btn(c_bell),
    .dbg_load(dbg_load), .dbg_fruit(dbg_fruit), .dbg_num(dbg_num),
    .turn(c_turn), .card_cnt(c_card), .pile_cnt(c_pile), .top_fruit(c_tf),
    .top_num(c_tn), .ring_ok(c_ok), .ring_bad(c_bad), .busy(c_busy),
    .game_over(c_go), .winner(c_win));

  // Ring scoreboards: 1 = expect ring_ok, 0 = expect ring_bad.
  bit qa[$];
  bit qb[$];
  bit qc[$];

  always @(negedge clk) begin
    bit e;
    if (!rst) begin
      if (a_ok || a_bad) begin
        if (qa.size() == 0) chk("a_unexpected_ring", {a_ok, a_bad}, 0);
        else begin
          e = qa.pop_front();
          chk("a_ring_ok", a_ok, e);
          chk("a_ring_bad", a_bad, !e);
        end
      end
      if (b_ok || b_bad) begin
        if (qb.size() == 0) chk("b_unexpected_ring", {b_ok, b_bad}, 0);
        else begin
          e = qb.pop_front();
          chk("b_ring_ok", b_ok, e);
          chk("b_ring_bad", b_bad, !e);
        end
      end
      if (c_ok || c_bad) begin
        if (qc.size() == 0) chk("c_unexpected_ring", {c_ok, c_bad}, 0);
        else begin
          e = qc.pop_front();
          chk("c_ring_ok", c_ok, e);
          chk("c_ring_bad", c_bad, !e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    a_flip = '0; a_bell = '0;
    b_flip = '0; b_bell = '0;
    c_flip = '0; c_bell = '0;
    dbg_load = 1'b1; dbg_fruit = 2'd0; dbg_num = 3'd1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // ---------------- A: reset state
    chk("a_rst_p0", a_card[5:0], 28);
    chk("a_rst_p1", a_card[11:6], 28);
    chk("a_rst_pile", a_pile, 0);
    chk("a_rst_turn", a_turn, 0);
    chk("a_rst_go", a_go, 0);
    chk("a_rst_tn", a_tn, 0);
    chk("a_rst_busy", a_busy, 0);

    // ---------------- A: out-of-turn flip ignored
    a_flip = 2'b10; tick(); a_flip = '0;
    chk("a_oot_p1", a_card[11:6], 28);
    chk("a_oot_pile", a_pile, 0);
    chk("a_oot_turn", a_turn, 0);

    // ---------------- A: P0 flips fruit 1 / 3
    dbg_fruit = 2'd1; dbg_num = 3'd3;
    a_flip = 2'b01; tick(); a_flip = '0;
    chk("a_f0_cnt", a_card[5:0], 27);
    chk("a_f0_pile", a_pile, 1);
    chk("a_f0_turn", a_turn, 1);
    chk("a_f0_tn", a_tn[2:0], 3);
    chk("a_f0_tf", a_tf[1:0], 1);

    // ---------------- A: P1 flips fruit 1 / 2 -> fruit 1 totals 5
    dbg_fruit = 2'd1; dbg_num = 3'd2;
    a_flip = 2'b10; tick(); a_flip = '0;
    chk("a_f1_cnt", a_card[11:6], 27);
    chk("a_f1_pile", a_pile, 2);
    chk("a_f1_turn", a_turn, 0);

    // ---------------- A: valid ring by P1
    qa.push_back(1'b1);
    a_bell = 2'b10; tick(); a_bell = '0;
    chk("a_ok_busy", a_busy, 1);
    tick();
    chk("a_col_p1", a_card[11:6], 29);
    chk("a_col_p0", a_card[5:0], 27);
    chk("a_col_pile", a_pile, 0);
    chk("a_col_tn", a_tn, 0);
    chk("a_col_tf", a_tf, 0);
    chk("a_col_turn", a_turn, 1);
    chk("a_col_busy", a_busy, 0);

    // ---------------- A: P1 flips fruit 2 / 1, then simultaneous events
    dbg_fruit = 2'd2; dbg_num = 3'd1;
    a_flip = 2'b10; tick(); a_flip = '0;
    chk("a_f2_cnt", a_card[11:6], 28);
    chk("a_f2_pile", a_pile, 1);
    chk("a_f2_turn", a_turn, 0);
    qa.push_back(1'b0);
    a_bell = 2'b11; a_flip = 2'b01; tick(); a_bell = '0; a_flip = '0;
    chk("a_sim_pile", a_pile, 1);
    chk("a_sim_tn0", a_tn[2:0], 0);
    chk("a_sim_busy", a_busy, 1);
    tick();
    chk("a_sim_p0", a_card[5:0], 26);
    chk("a_sim_p1", a_card[11:6], 29);
    chk("a_sim_pile2", a_pile, 1);
    chk("a_sim_turn", a_turn, 0);
    chk("a_sim_busy2", a_busy, 0);

    // ---------------- B: invalid ring by P2 with N=4
    chk("b_rst_p2", b_card[20:14], 28);
    qb.push_back(1'b0);
    b_bell = 4'b0100; tick(); b_bell = '0;
    n = 0;
    for (int g = 0; g < 10 && b_busy; g++) begin
      n++;
      tick();
    end
    chk("b_busy_cycles", n, 3);
    chk("b_pen_p0", b_card[6:0], 29);
    chk("b_pen_p1", b_card[13:7], 29);
    chk("b_pen_p2", b_card[20:14], 25);
    chk("b_pen_p3", b_card[27:21], 29);
    chk("b_pen_pile", b_pile, 0);
    chk("b_pen_turn", b_turn, 0);

    // ---------------- C: game over with DECK=1
    chk("c_rst_card", c_card, 4'b0101);
    dbg_fruit = 2'd0; dbg_num = 3'd1;
    c_flip = 2'b01; tick(); c_flip = '0;
    chk("c_go_p0", c_card[1:0], 0);
    chk("c_go_p1", c_card[3:2], 1);
    chk("c_go_pile", c_pile, 1);
    chk("c_go_level", c_go, 1);
    chk("c_go_winner", c_win, 1);
    c_flip = 2'b11; c_bell = 2'b11; tick(); tick(); c_flip = '0; c_bell = '0;
    tick();
    chk("c_hold_p1", c_card[3:2], 1);
    chk("c_hold_pile", c_pile, 1);
    chk("c_hold_go", c_go, 1);
    chk("c_hold_win", c_win, 1);
    chk("c_hold_turn", c_turn, 1);

    // ---------------- B: reset in the middle of a penalty
    qb.push_back(1'b0);
    b_bell = 4'b0010; tick(); b_bell = '0;
    tick();
    chk("b_mid_busy", b_busy, 1);
    chk("b_mid_p1", b_card[13:7], 28);
    rst = 1'b1;
    #2;
    chk("b_rr_p0", b_card[6:0], 28);
    chk("b_rr_p1", b_card[13:7], 28);
    chk("b_rr_p2", b_card[20:14], 28);
    chk("b_rr_p3", b_card[27:21], 28);
    chk("b_rr_pile", b_pile, 0);
    chk("b_rr_busy", b_busy, 0);
    chk("b_rr_turn", b_turn, 0);
    chk("b_rr_go", b_go, 0);
    chk("b_rr_flags", {b_ok, b_bad}, 0);
    chk("a_rr_card", a_card, {6'd28, 6'd28});
    chk("a_rr_pile", a_pile, 1'b0);
    chk("c_rr_go", c_go, 0);
    chk("c_rr_win", c_win, 0);
    chk("c_rr_card", c_card, 4'b0101);
    chk("c_rr_tn", c_tn, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    tick();

    chk("a_sb_left", qa.size(), 0);
    chk("b_sb_left", qb.size(), 0);
    chk("c_sb_left", qc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_halli_galli_engine
`default_nettype wire
